// File: rtl/tdm_demux16.sv
// Receive side of a 16-channel single-lane TDM link: collects one sample per
// valid cycle into a shadow frame and publishes all 16 channels at once.
module tdm_demux16 #(
  parameter int W = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  input  logic          sof,
  output logic [16*W-1:0] dout,
  output logic          frame_valid,
  output logic [3:0]    chan,
  output logic          locked,
  output logic          sync_err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_chan;
  logic [3:0]          w_chan_nxt;
  // Slot 15 is never stored: it goes straight from din into dout on commit.
  logic [15*W-1:0]     r_shadow;
  logic [15*W-1:0]     w_shadow_nxt;
  logic [16*W-1:0]     r_dout;
  logic [16*W-1:0]     w_dout_nxt;
  logic                r_frame_valid;
  logic                w_frame_valid_nxt;
  logic                r_sync_err;
  logic                w_sync_err_nxt;
  logic                r_locked;

  // Next-state and next-output decode for one input cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_chan_nxt        = r_chan;
    w_shadow_nxt      = r_shadow;
    w_dout_nxt        = r_dout;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (sof) begin
            w_shadow_nxt[0 +: W] = din;
            w_chan_nxt           = 4'd1;
            w_state_nxt          = RECV;
          end else begin
            w_state_nxt = HUNT;
          end
        end
        RECV: begin
          if (sof) begin
            // A sof anywhere but slot 0 aborts the partial frame and restarts.
            w_sync_err_nxt       = (r_chan != 4'd0);
            w_shadow_nxt[0 +: W] = din;
            w_chan_nxt           = 4'd1;
          end else if (r_chan == 4'd0) begin
            w_sync_err_nxt = 1'b1;
            w_state_nxt    = HUNT;
          end else if (r_chan == 4'd15) begin
            w_dout_nxt        = {din, r_shadow};
            w_frame_valid_nxt = 1'b1;
            w_chan_nxt        = 4'd0;
          end else begin
            w_shadow_nxt[r_chan*W +: W] = din;
            w_chan_nxt                  = r_chan + 4'd1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_chan_nxt  = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, shadow frame and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state       <= HUNT;
      r_chan        <= 4'd0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_chan        <= w_chan_nxt;
      r_shadow      <= w_shadow_nxt;
      r_dout        <= w_dout_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
      r_locked      <= (w_state_nxt == RECV);
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign chan        = r_chan;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
Time-division demultiplexer: the receive end of a 16-channel single-lane TDM link, the inverse of the 16:1 channel selector.
- Accepts one W-bit sample per valid cycle on a single input lane; sample order is channel 0..15; `sof` marks channel 0.
- Rebuilds each frame in a shadow register, then presents all 16 channels in parallel with a frame-valid strobe.
- Sits between the serial link and per-channel consumers.

Parameters:
W  1  bits per channel sample

Ports:
Clock        in   1      system clock, rising edge
Resetn       in   1      asynchronous active-low reset
din          in   W      sample for the current channel
din_valid    in   1      din/sof qualify this cycle; no backpressure
sof          in   1      start of frame; valid only with din_valid; marks channel 0
dout         out  16*W   last complete frame; channel k at dout[k*W +: W]
frame_valid  out  1      one-cycle pulse: dout updated this cycle
chan         out  4      slot index the next sample will fill
locked       out  1      1 when in RECV state
sync_err     out  1      one-cycle pulse on a framing violation

Behaviour:
- Reset: Clock and Resetn are the only clock/reset. Resetn low asynchronously clears the state to HUNT, and sets chan=0, shadow=0, dout=0, frame_valid=0, sync_err=0, locked=0. This applies at any point, including mid-frame; any partial frame is discarded.
- All outputs are registered. frame_valid and sync_err default to 0 every cycle unless set below.
- Cycles with din_valid=0 change nothing: counters hold and no pulses are produced. Gaps of any length are legal, mid-frame included.
- `sof` with din_valid=0 is ignored.
- State HUNT:
  - din_valid & !sof: sample dropped, no error, stay in HUNT.
  - din_valid & sof: shadow[0]<=din, chan<=1, go to RECV.
- State RECV, on each din_valid cycle:
  - !sof & chan in 1..15: shadow[chan]<=din, chan<=chan+1 (4-bit wrap, so 15->0).
  - !sof & chan==15: additionally dout<={din, shadow[14:0]} and frame_valid<=1 on the same edge. Latency is therefore one edge from the channel-15 sample to dout and frame_valid.
  - sof & chan==0: shadow[0]<=din, chan<=1. This is the normal back-to-back frame start.
  - sof & chan!=0 (early sof): sync_err<=1, partial frame discarded, shadow[0]<=din, chan<=1, stay in RECV. dout is not updated.
  - !sof & chan==0 (missing sof): sync_err<=1, sample dropped, chan stays 0, go to HUNT.
- dout changes only on frame completion and never shows a partial frame. It holds its value across HUNT, gaps and errors until the next complete frame.
- Shadow slots are not cleared between frames. Every slot is rewritten before the next commit.
- locked is 1 exactly while the state is RECV.
- Minimum frame length is 16 valid cycles. Back-to-back frames give one frame_valid every 16 valid cycles.
- sof and a completing channel-15 sample cannot coincide: sof there is an early-sof error, the frame is not committed, and the sof sample is taken as the new channel 0.

Test Plan:
1. W=4, reset, then 16 consecutive valid samples din=k for k=0..15, with sof on k=0 -> frame_valid pulses once on the edge after k=15; dout=0xFEDCBA9876543210; locked=1; chan=0; sync_err never asserted.
2. Same frame with din_valid low on random cycles (including 5 idle cycles between k=7 and k=8) -> identical dout; exactly one frame_valid, 16 valid samples after sof; chan holds during the gaps.
3. Valid samples 3,4,5 with no sof after reset, then a full frame with din=0xA in every slot -> first three samples dropped with no sync_err; then dout=0xAAAAAAAAAAAAAAAA.
4. Frame 1 all 0x1 completes; frame 2 gets sof at k=0, then a new sof at k=6 followed by 15 samples of 0x2 -> sync_err pulse on the second sof; no frame_valid at the aborted point; final dout has slot0 = the sof sample and slots 1..15 = 0x2. dout holds 0x1111111111111111 until then.
5. Complete frame, then next valid sample without sof -> sync_err pulse; locked drops to 0; dout unchanged; next sof relocks.
6. Assert Resetn low asynchronously mid-clock at k=9 of a frame -> immediately dout=0, locked=0, chan=0. After release, a full frame decodes correctly with no residue from the aborted frame.
